neuron_access_ctrl: RTL and testbench

- Host-side controller sequencing external reads and writes into the Poisson neuron array memory over the ext_req/ext_ack port.
- Buffers host commands in a small FIFO and holds each request until the neuron array acknowledges it, which it does only when its internal scroll is idle.
- Returns read data through a valid/ready response channel.
- Provides a bulk fill sequencer that initialises every neuron entry to one value.

---
 rtl/neuron_access_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_neuron_access_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : neuron_access_ctrl
// Purpose  : Host-side sequencer for reads/writes into the Poisson neuron
//            array memory. Queues host commands in a small FIFO, holds each
//            request on ext_req until the array acknowledges it, returns read
//            data over a valid/ready channel, and provides a bulk fill engine.
// Revision : 1.0 - initial release
// ============================================================================
module neuron_access_ctrl #(
  parameter  int NEURON_NUMBER = 256,
  parameter  int NEUR_WIDTH    = 13,
  parameter  int CMD_DEPTH     = 4,
  parameter  int WAIT_LIMIT    = 1024,
  localparam int AW            = $clog2(NEURON_NUMBER)
) (
  input  logic                  clk,
  input  logic                  reset,
  // host command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [AW-1:0]         cmd_addr,
  input  logic [NEUR_WIDTH-1:0] cmd_data,
  // host read response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [AW-1:0]         rsp_addr,
  output logic [NEUR_WIDTH-1:0] rsp_data,
  // bulk fill
  input  logic                  fill_start,
  input  logic [NEUR_WIDTH-1:0] fill_data,
  output logic                  fill_busy,
  output logic                  starve_err,
  // neuron array port
  output logic                  ext_req,
  input  logic                  ext_ack,
  output logic                  ext_we,
  output logic                  ext_re,
  output logic [AW-1:0]         ext_neur_addr,
  output logic [NEUR_WIDTH-1:0] ext_neur_data_in,
  input  logic [NEUR_WIDTH-1:0] ext_neur_data_out
);

  localparam int PW  = $clog2(CMD_DEPTH) + 1;   // pointer width incl. wrap bit
  localparam int IW  = PW - 1;                  // FIFO index width
  localparam int WCW = $clog2(WAIT_LIMIT + 1);  // starvation counter width

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_RD_CAP = 3'd2,
    S_RSP    = 3'd3,
    S_FILL   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic                    fifo_we_q   [CMD_DEPTH];
  logic                    fifo_we_d   [CMD_DEPTH];
  logic [AW-1:0]           fifo_addr_q [CMD_DEPTH];
  logic [AW-1:0]           fifo_addr_d [CMD_DEPTH];
  logic [NEUR_WIDTH-1:0]   fifo_data_q [CMD_DEPTH];
  logic [NEUR_WIDTH-1:0]   fifo_data_d [CMD_DEPTH];
  logic [AW-1:0]           fill_cnt_q, fill_cnt_d;
  logic [NEUR_WIDTH-1:0]   fill_val_q, fill_val_d;
  logic [AW-1:0]           rsp_addr_q, rsp_addr_d;
  logic [NEUR_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [WCW-1:0]          wait_cnt_q, wait_cnt_d;
  logic                    starve_q, starve_d;

  logic [PW-1:0]           count;
  logic                    empty, full, push, pop;
  logic [IW-1:0]           rd_idx, wr_idx;
  logic                    head_we;
  logic [AW-1:0]           head_addr;
  logic [NEUR_WIDTH-1:0]   head_data;
  logic                    wait_at_limit;

  // FIFO status, head entry and array-side drive decoded from current state
  always_comb begin
    rd_idx    = rd_ptr_q[IW-1:0];
    wr_idx    = wr_ptr_q[IW-1:0];
    count     = wr_ptr_q - rd_ptr_q;
    empty     = (count == '0);
    full      = (count == PW'(CMD_DEPTH));
    head_we   = fifo_we_q[rd_idx];
    head_addr = fifo_addr_q[rd_idx];
    head_data = fifo_data_q[rd_idx];

    // no new commands while filling or when a fill is being launched
    cmd_ready = ~reset & ~full & (state_q != S_FILL) & ~fill_start;
    push      = cmd_valid & cmd_ready;
    pop       = (state_q == S_ACCESS) & ext_ack;

    ext_req          = (state_q == S_ACCESS) | (state_q == S_FILL);
    ext_we           = ((state_q == S_ACCESS) & head_we) | (state_q == S_FILL);
    ext_re           = (state_q == S_ACCESS) & ~head_we;
    ext_neur_addr    = (state_q == S_FILL) ? fill_cnt_q : head_addr;
    ext_neur_data_in = (state_q == S_FILL) ? fill_val_q : head_data;

    rsp_valid  = (state_q == S_RSP);
    rsp_addr   = rsp_addr_q;
    rsp_data   = rsp_data_q;
    fill_busy  = (state_q == S_FILL);
    starve_err = starve_q;

    wait_at_limit = (wait_cnt_q == WCW'(WAIT_LIMIT - 1));
  end

  // next-state, FIFO update, fill counter and starvation tracking
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_we_d   = fifo_we_q;
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    fill_cnt_d  = fill_cnt_q;
    fill_val_d  = fill_val_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    wait_cnt_d  = '0;
    starve_d    = starve_q | wait_at_limit;

    if (push) begin
      fifo_we_d[wr_idx]   = cmd_we;
      fifo_addr_d[wr_idx] = cmd_addr;
      fifo_data_d[wr_idx] = cmd_data;
      wr_ptr_d            = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // saturate so a long stall cannot wrap back below the limit
    if (ext_req & ~ext_ack) begin
      wait_cnt_d = wait_at_limit ? wait_cnt_q : wait_cnt_q + WCW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (fill_start) begin
          state_d    = S_FILL;
          fill_val_d = fill_data;
          fill_cnt_d = '0;
        end else if (!empty) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (ext_ack) begin
          if (head_we) begin
            // back-to-back writes while more entries sit behind the head
            state_d = (count > PW'(1)) ? S_ACCESS : S_IDLE;
          end else begin
            rsp_addr_d = head_addr;
            state_d    = S_RD_CAP;
          end
        end
      end
      S_RD_CAP: begin
        // array read data is registered: valid the cycle after the ack
        rsp_data_d = ext_neur_data_out;
        state_d    = S_RSP;
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        if (ext_ack) begin
          if (fill_cnt_q == AW'(NEURON_NUMBER - 1)) begin
            state_d = S_IDLE;
          end else begin
            fill_cnt_d = fill_cnt_q + AW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // register all state; reset aborts any access or fill in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_cnt_q <= '0;
      fill_val_q <= '0;
      rsp_addr_q <= '0;
      rsp_data_q <= '0;
      wait_cnt_q <= '0;
      starve_q   <= 1'b0;
      for (int i = 0; i < CMD_DEPTH; i++) begin
        fifo_we_q[i]   <= 1'b0;
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      fill_val_q  <= fill_val_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
      wait_cnt_q  <= wait_cnt_d;
      starve_q    <= starve_d;
      fifo_we_q   <= fifo_we_d;
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_neuron_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_access_ctrl
// Purpose  : Directed self-checking bench for neuron_access_ctrl with a
//            behavioural neuron-array model (registered read data).
// Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_access_ctrl;

  localparam int AW = 8;
  localparam int NW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [NW-1:0] cmd_data;
  logic          rsp_valid, rsp_ready;
  logic [AW-1:0] rsp_addr;
  logic [NW-1:0] rsp_data;
  logic          fill_start, fill_busy, starve_err;
  logic [NW-1:0] fill_data;
  logic          ext_req, ext_ack, ext_we, ext_re;
  logic [AW-1:0] ext_neur_addr;
  logic [NW-1:0] ext_neur_data_in;
  logic [NW-1:0] ext_neur_data_out;

  // ack source: level from ack_en, or a 1/0 toggle when tog_mode is set
  logic ack_en, tog_mode, tog_q;
  assign ext_ack = tog_mode ? tog_q : ack_en;

  neuron_access_ctrl #(
    .NEURON_NUMBER(256), .NEUR_WIDTH(13), .CMD_DEPTH(4), .WAIT_LIMIT(1024)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .fill_start(fill_start), .fill_data(fill_data), .fill_busy(fill_busy),
    .starve_err(starve_err),
    .ext_req(ext_req), .ext_ack(ext_ack), .ext_we(ext_we), .ext_re(ext_re),
    .ext_neur_addr(ext_neur_addr), .ext_neur_data_in(ext_neur_data_in),
    .ext_neur_data_out(ext_neur_data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [NW-1:0] data;
    int            cyc;
  } acc_t;

  acc_t          log_q[$];
  logic [NW-1:0] mem [256];
  int            cyc = 0;
  int            req_cnt = 0;

  // neuron array model: logs every acknowledged access in order
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    tog_q <= ~tog_q;
    if (ext_req) req_cnt <= req_cnt + 1;
    if (!reset && ext_req && ext_ack) begin
      log_q.push_back('{we: ext_we, addr: ext_neur_addr, data: ext_neur_data_in, cyc: cyc});
      if (ext_we) mem[ext_neur_addr] <= ext_neur_data_in;
      if (ext_re) ext_neur_data_out <= mem[ext_neur_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic we, input logic [AW-1:0] a, input logic [NW-1:0] d);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_data = d;
    #1;
    check("cmd_ready_push", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int k;
    k = 0;
    while (!rsp_valid && k < 20) begin
      tick();
      k++;
    end
    check("rsp_wait", {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin
    int r0, bad, done, end_cyc, w;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    ext_neur_data_out = '0;
    tog_q = 1'b0; tog_mode = 1'b0; ack_en = 1'b1;
    reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_data = '0;
    rsp_ready = 1'b0; fill_start = 1'b0; fill_data = '0;

    // ---- reset state
    repeat (3) tick();
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_ext_req",   {31'd0, ext_req}, 32'd0);
    check("rst_outs", {27'd0, rsp_valid, fill_busy, starve_err, ext_we, ext_re}, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // ---- single write, ack tied high
    log_q.delete();
    r0 = req_cnt;
    push_cmd(1'b1, 8'd10, 13'h1ABC);
    repeat (6) tick();
    check("wr_req_cycles", req_cnt - r0, 32'd1);
    check("wr_log_size", log_q.size(), 32'd1);
    check("wr_entry", {log_q[0].we, 3'd0, log_q[0].addr, 3'd0, log_q[0].data}, {1'b1, 3'd0, 8'd10, 3'd0, 13'h1ABC});
    check("wr_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // ---- read back, response held for 5 cycles
    log_q.delete();
    push_cmd(1'b0, 8'd10, 13'h0000);
    wait_rsp();
    check("rd_addr", {24'd0, rsp_addr}, 32'd10);
    check("rd_data", {19'd0, rsp_data}, 32'h1ABC);
    check("rd_log_re", {31'd0, log_q[0].we}, 32'd0);
    r0 = req_cnt;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!rsp_valid || rsp_addr !== 8'd10 || rsp_data !== 13'h1ABC) bad++;
    end
    check("rd_hold_stable", bad, 32'd0);
    check("rd_hold_no_req", req_cnt - r0, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rd_rsp_drop", {31'd0, rsp_valid}, 32'd0);

    // ---- four writes queued against a stalled array
    log_q.delete();
    ack_en = 1'b0;
    for (int i = 1; i <= 4; i++) push_cmd(1'b1, AW'(i), NW'(13'h100 + i));
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'd5; cmd_data = 13'h105;
    #1;
    check("fifo_full_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    cmd_valid = 1'b0;
    repeat (15) tick();
    check("stall_no_acc", log_q.size(), 32'd0);
    ack_en = 1'b1;
    repeat (8) tick();
    check("b2b_log_size", log_q.size(), 32'd4);
    bad = 0;
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      if (log_q[i].addr !== AW'(i + 1) || log_q[i].data !== NW'(13'h101 + i) ||
          log_q[i].cyc != log_q[0].cyc + i) bad++;
    end
    check("b2b_order_consecutive", bad, 32'd0);
    check("b2b_no_starve", {31'd0, starve_err}, 32'd0);

    // ---- bulk fill with toggling ack; host keeps offering a command
    log_q.delete();
    fill_start = 1'b1; fill_data = 13'h0000;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'd7; cmd_data = 13'h0777;
    #1;
    check("fill_start_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    fill_start = 1'b0; fill_data = 13'h1FFF; tog_mode = 1'b1;
    check("fill_busy_on", {31'd0, fill_busy}, 32'd1);
    bad = 0; done = 0; end_cyc = 0;
    for (int i = 0; i < 800; i++) begin
      if (!fill_busy) begin
        done = 1; end_cyc = cyc;
        break;
      end
      if (cmd_ready) bad++;
      tick();
    end
    cmd_valid = 1'b0; tog_mode = 1'b0;
    check("fill_done", done, 32'd1);
    check("fill_cmd_ready_low", bad, 32'd0);
    check("fill_count", log_q.size(), 32'd256);
    bad = 0;
    for (int i = 0; i < log_q.size(); i++)
      if (log_q[i].addr !== AW'(i) || log_q[i].data !== 13'h0000 || log_q[i].we !== 1'b1) bad++;
    check("fill_seq", bad, 32'd0);
    if (log_q.size() > 0) check("fill_busy_drop", end_cyc, log_q[log_q.size()-1].cyc + 1);
    else check("fill_busy_drop", 32'd0, 32'd1);
    repeat (3) tick();
    check("fill_no_cmd_leak", log_q.size(), 32'd256);

    // ---- starvation during a read
    ack_en = 1'b1;
    push_cmd(1'b1, 8'd200, 13'h0F0F);
    repeat (4) tick();
    ack_en = 1'b0;
    push_cmd(1'b0, 8'd200, 13'h0000);
    w = 0;
    for (int i = 0; i < 1200 && w < 1025; i++) begin
      tick();
      if (ext_req && !ext_ack) begin
        w++;
        if (w == 1024) check("starve_before_limit", {31'd0, starve_err}, 32'd0);
        if (w == 1025) check("starve_set", {31'd0, starve_err}, 32'd1);
      end
    end
    check("starve_wait_reached", w, 32'd1025);
    ack_en = 1'b1;
    wait_rsp();
    check("starve_rd_data", {19'd0, rsp_data}, 32'h0F0F);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("starve_sticky", {31'd0, starve_err}, 32'd1);

    // ---- reset in the middle of a fill, then restart
    log_q.delete();
    fill_start = 1'b1; fill_data = 13'h0AAA;
    tick();
    fill_start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (log_q.size() >= 100) break;
      tick();
    end
    check("midfill_addr", {24'd0, ext_neur_addr}, 32'd100);
    reset = 1'b1;
    tick();
    check("midrst_outs", {26'd0, ext_req, ext_we, ext_re, fill_busy, starve_err, rsp_valid}, 32'd0);
    check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("midrst_addr_data", {11'd0, ext_neur_addr, ext_neur_data_in}, 32'd0);
    reset = 1'b0;
    tick();
    log_q.delete();
    fill_start = 1'b1; fill_data = 13'h0123;
    tick();
    fill_start = 1'b0;
    repeat (3) tick();
    check("refill_started", {31'd0, log_q.size() > 0}, 32'd1);
    if (log_q.size() > 0)
      check("refill_first", {log_q[0].addr, 11'd0, log_q[0].data}, {8'd0, 11'd0, 13'h0123});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
